// File: rtl/coin_slot_scheduler.sv
// coin_slot_scheduler: synchronises NSLOT coin slots, round-robins captures into a coin FIFO and replays gapped pulses.
// Optional COIN_REJECT_EN: multi-hot codes are dropped and reported on reject/reject_slot instead of being reduced.
module coin_slot_scheduler #(
    parameter int NSLOT       = 4,
    parameter int DEPTH       = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3*NSLOT-1:0]       slot_coin,
    input  logic                     vm_soda,
    input  logic                     ovf_clr,
    output logic                     vm_nickle,
    output logic                     vm_dime,
    output logic                     vm_quarter,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
`ifdef COIN_REJECT_EN
    output logic                     reject,
    output logic [$clog2(NSLOT)-1:0] reject_slot,
`endif
    output logic                     ovf
);
    localparam int AW   = $clog2(DEPTH);
    localparam int SW   = $clog2(NSLOT);
    localparam int TMAX = GAP_CYCLES > HOLD_CYCLES ? GAP_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, HOLD} state_t;

    logic [3*NSLOT-1:0] sync_q [SYNC_STAGES];
    logic [3*NSLOT-1:0] prev_q, cur;
    logic [NSLOT-1:0]   cap, take, pend_q, gnt, drop;
    logic [1:0]         code [NSLOT];
    logic [1:0]         pend_code_q [NSLOT];
    logic [SW-1:0]      rr_q, gnt_idx;
    logic               gnt_any, full, pop;
    logic [1:0]         mem [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;
    state_t             state_q, state_d;
    logic [CW-1:0]      tmr_q, tmr_d;
    logic [2:0]         vm_q;

    assign cur = sync_q[SYNC_STAGES-1];
    assign full = cnt_q == (AW+1)'(DEPTH);

    // Slot bit 3i is nickle, 3i+1 dime, 3i+2 quarter; code 0=N, 1=D, 2=Q with quarter winning on multi-hot.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            cap[i]  = prev_q[3*i +: 3] == 3'b000 && cur[3*i +: 3] != 3'b000;
            code[i] = cur[3*i+2] ? 2'd2 : cur[3*i+1] ? 2'd1 : 2'd0;
        end
    end

`ifdef COIN_REJECT_EN
    logic [NSLOT-1:0] bad;
    always_comb begin
        bad = '0;
        reject_slot = '0;
        for (int i = NSLOT-1; i >= 0; i--) begin
            bad[i] = cap[i] && !(cur[3*i +: 3] inside {3'b001, 3'b010, 3'b100});
            if (bad[i]) reject_slot = SW'(i);
        end
    end
    assign reject = |bad;
    assign take = cap & ~bad;
`else
    assign take = cap;
`endif

    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NSLOT; k++) begin
            if (!gnt_any && !full && pend_q[(int'(rr_q) + k) % NSLOT]) begin
                gnt_any = 1'b1;
                gnt_idx = SW'((int'(rr_q) + k) % NSLOT);
            end
        end
        gnt[gnt_idx] = gnt_any;
        drop = take & pend_q & ~gnt;
    end

    // A grant frees the slot in the same cycle, so a simultaneous capture becomes the new pending coin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < NSLOT; i++) pend_code_q[i] <= '0;
            prev_q <= '0;
            pend_q <= '0;
            rr_q   <= SW'(NSLOT-1);
            ovf    <= 1'b0;
        end else begin
            sync_q[0] <= slot_coin;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= cur;
            for (int i = 0; i < NSLOT; i++) begin
                if (take[i] && (!pend_q[i] || gnt[i])) begin
                    pend_q[i]      <= 1'b1;
                    pend_code_q[i] <= code[i];
                end else if (gnt[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
            if (gnt_any) rr_q <= gnt_idx;
            ovf <= |drop || (ovf && !ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any) mem[wr_q] <= pend_code_q[gnt_idx];
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                pop     = cnt_q != '0;
                state_d = pop ? PULSE : IDLE;
            end
            PULSE: begin
                state_d = GAP;
                tmr_d   = CW'(GAP_CYCLES);
            end
            GAP, HOLD: begin
                tmr_d   = tmr_q - 1'b1;
                state_d = tmr_q <= CW'(1) ? IDLE : state_q;
            end
        endcase
        if (vm_soda) begin
            state_d = HOLD;
            tmr_d   = CW'(HOLD_CYCLES);
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            tmr_q   <= '0;
            vm_q    <= '0;
        end else begin
            if (gnt_any) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_q + (AW+1)'(gnt_any) - (AW+1)'(pop);
            state_q <= state_d;
            tmr_q   <= tmr_d;
            vm_q    <= pop ? 3'b001 << mem[rd_q] : 3'b000;
        end
    end

    assign vm_nickle  = vm_q[0];
    assign vm_dime    = vm_q[1];
    assign vm_quarter = vm_q[2];
    assign fifo_level = cnt_q;
    assign busy       = |pend_q || cnt_q != '0 || state_q != IDLE;
endmodule
